// File: rtl/unigate_cfg_seq.sv
// unigate_cfg_seq: Wishbone-programmed serialiser for a unigate config chain.
// Ports: wb_clk_i/wb_rst_ni clock and sync low reset; wbs_* Wishbone slave
//   (16-byte window at BASE_ADDR); cfg_data_o/cfg_shift_o/cfg_latch_o chain
//   drive; irq_o level interrupt (DONE & IRQ_EN, registered).
module unigate_cfg_seq #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cfg_data_o,
  output logic        cfg_shift_o,
  output logic        cfg_latch_o,
  output logic        irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t      state_q, state_d;

  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rdata;

  logic [15:0] len_q;
  logic        irq_en_q;
  logic        done_q;
  logic        ovf_q;
  logic        irq_q;

  logic [15:0] remain_q, remain_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] sh_q, sh_d;
  logic        done_set;
  logic        done_clr;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [4:0]    level_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ovf_set;

  logic        hit;
  logic        acc;
  logic        wr;
  logic        rd;
  logic [1:0]  sel;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        wr_data;
  logic        start;
  logic        abort;

  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

  // Bus decode. A hit is accepted only while no ack is pending, so a
  // held strobe yields an ack on alternate cycles.
  assign hit = wbs_cyc_i & wbs_stb_i
             & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc = hit & ~ack_q;
  assign wr  = acc & wbs_we_i;
  assign rd  = acc & ~wbs_we_i;
  assign sel = wbs_adr_i[3:2];

  assign wr_ctrl = wr & (sel == 2'd0);
  assign wr_stat = wr & (sel == 2'd1);
  assign wr_data = wr & (sel == 2'd2);
  assign start   = wr_ctrl & wbs_dat_i[0];
  assign abort   = wr_ctrl & wbs_dat_i[1];

  // FIFO control. A pop frees the slot the push needs, so push at full
  // is legal when a pop happens in the same cycle.
  assign full    = (level_q == DEPTH5);
  assign empty   = (level_q == 5'd0);
  assign pop     = (state_q == S_LOAD) & ~empty & ~abort;
  assign push    = wr_data & (~full | pop);
  assign ovf_set = wr_data & full & ~pop;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel == 2'd0: rdata = {len_q, 13'd0, irq_en_q, 2'b00};
      sel == 2'd1: rdata = {19'd0, level_q, 2'b00, ovf_q, 1'b0,
                            empty, full, done_q,
                            (state_q != S_IDLE)};
      sel == 2'd2: rdata = '0;
      sel == 2'd3: rdata = {16'd0, remain_q};
      default:     rdata = '0;
    endcase
  end

  // Sequencer next state. The START length comes from the same write so
  // that LEN and START can be programmed together.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    done_set = 1'b0;
    done_clr = 1'b0;
    if (abort) begin
      state_d  = S_IDLE;
      remain_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (wbs_dat_i[31:16] != 16'd0)) begin
            state_d  = S_LOAD;
            remain_d = wbs_dat_i[31:16];
            done_clr = 1'b1;
          end
        end
        S_LOAD: begin
          if (!empty) begin
            sh_d    = mem_q[rptr_q];
            idx_d   = '0;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          remain_d = remain_q - 16'd1;
          idx_d    = idx_q + 5'd1;
          if (remain_q == 16'd1) begin
            state_d = S_LATCH;
          end else if (idx_q == 5'd31) begin
            state_d = S_LOAD;
          end
        end
        S_LATCH: begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= rd ? rdata : 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      len_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        len_q    <= wbs_dat_i[31:16];
        irq_en_q <= wbs_dat_i[2];
      end
      if (done_set) begin
        done_q <= 1'b1;
      end else if (done_clr || (wr_stat && wbs_dat_i[1])) begin
        done_q <= 1'b0;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (wr_stat && wbs_dat_i[5]) begin
        ovf_q <= 1'b0;
      end
      irq_q <= done_q & irq_en_q;
    end
  end

  // Pointers are AW bits wide, so they wrap at the power-of-two depth.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (abort) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      unique case (1'b1)
        push && !pop: level_q <= level_q + 5'd1;
        pop && !push: level_q <= level_q - 5'd1;
        default:      level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= wbs_dat_i;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign cfg_shift_o = (state_q == S_SHIFT);
  assign cfg_data_o  = cfg_shift_o & sh_q[idx_q];
  assign cfg_latch_o = (state_q == S_LATCH);
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_unigate_cfg_seq.sv
// tb_unigate_cfg_seq: scoreboard bench for unigate_cfg_seq.
// Expected chain bits and read data are queued at stimulus time.
module tb_unigate_cfg_seq;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DATA = BASE + 32'h8;
  localparam logic [31:0] A_REM  = BASE + 32'hC;

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        cdata;
  logic        cshift;
  logic        clatch;
  logic        irq;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int run_n = 0;
  int run_t [128];
  int latch_n = 0;
  int latch_t = 0;
  logic        bit_q [$];
  logic [31:0] rd_q [$];

  unigate_cfg_seq #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(4)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .cfg_data_o (cdata),
    .cfg_shift_o(cshift),
    .cfg_latch_o(clatch),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cshift === 1'b1) begin
      if (run_n < 128) run_t[run_n] = cyc_n;
      run_n++;
      if (bit_q.size() == 0) begin
        chk("extra_shift", 1, 0);
      end else begin
        chk("cfg_bit", cdata, bit_q.pop_front());
      end
    end else begin
      chk("idle_data", cdata, 0);
    end
    if (clatch === 1'b1) begin
      latch_n++;
      latch_t = cyc_n;
    end
  end

  task automatic wb_cycle(input logic [31:0] a, input logic w,
                          input logic [31:0] d,
                          output logic [31:0] r, output logic ok);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d;
    ok = 0;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        ok = 1;
        r = rdat;
        break;
      end
    end
    cyc = 0; stb = 0; we = 0;
    if (!ok) chk("ack_timeout", 0, 1);
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic ok;
    wb_cycle(a, 1'b1, d, r, ok);
  endtask

  task automatic wb_rd(input logic [31:0] a, input logic [31:0] e,
                       input string tag);
    logic [31:0] r;
    logic [31:0] x;
    logic ok;
    rd_q.push_back(e);
    wb_cycle(a, 1'b0, 32'd0, r, ok);
    x = rd_q.pop_front();
    if (ok) chk(tag, r, x);
  endtask

  task automatic push_bits(input logic [31:0] w0, input logic [31:0] w1,
                           input int len);
    for (int i = 0; i < len; i++) begin
      bit_q.push_back(i < 32 ? w0[i] : w1[i-32]);
    end
  endtask

  task automatic wait_latch(input int budget);
    int l0;
    l0 = latch_n;
    for (int i = 0; i < budget && latch_n == l0; i++) begin
      @(posedge clk); #1;
    end
    if (latch_n == l0) chk("latch_timeout", 0, 1);
  endtask

  task automatic wait_shifts(input int n, input int budget);
    for (int i = 0; i < budget && run_n < n; i++) begin
      @(posedge clk); #1;
    end
    if (run_n < n) chk("shift_timeout", run_n, n);
  endtask

  initial begin
    int seen;
    int l0;
    rst_n = 0; cyc = 0; stb = 0; we = 0;
    sel = 4'hF; adr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dat", rdat, 0);
    chk("rst_outs", {ack, cdata, cshift, clatch, irq}, 0);
    rst_n = 1;
    wb_rd(A_STAT, 32'h8, "rst_status");
    wb_rd(A_REM, 32'h0, "rst_remain");

    // Out-of-window access must never be acked.
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h10;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) seen = 1;
    end
    cyc = 0; stb = 0;
    chk("nohit_ack", seen, 0);

    // Held strobe: ack lasts one cycle, read data only with ack.
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = A_STAT;
    @(posedge clk); #1;
    chk("ack_first", {ack, rdat}, {1'b1, 32'h8});
    @(posedge clk); #1;
    chk("ack_drop", {ack, rdat}, 0);
    cyc = 0; stb = 0;

    // START with LEN==0 is ignored.
    wb_wr(A_CTRL, 32'h0000_0001);
    wb_rd(A_STAT, 32'h8, "len0_status");

    // 8-bit load of 0xA5 with interrupt.
    wb_wr(A_DATA, 32'h0000_00A5);
    push_bits(32'hA5, 32'h0, 8);
    run_n = 0;
    wb_wr(A_CTRL, 32'h0008_0005);
    wait_latch(200);
    chk("s1_nbits", run_n, 8);
    chk("s1_latch_t", latch_t, run_t[7] + 1);
    chk("s1_left", bit_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("s1_irq", irq, 1);
    wb_rd(A_STAT, 32'h0000_000A, "s1_status");
    wb_rd(A_CTRL, 32'h0008_0004, "s1_ctrl");
    wb_wr(A_STAT, 32'h2);
    @(posedge clk); #1;
    chk("s1_irq_clr", irq, 0);

    // 40 bits over two words, with the refill bubble.
    wb_wr(A_DATA, 32'h1234_5678);
    wb_wr(A_DATA, 32'hCAFE_F00D);
    push_bits(32'h1234_5678, 32'hCAFE_F00D, 40);
    run_n = 0;
    wb_wr(A_CTRL, 32'h0028_0001);
    wait_latch(300);
    chk("s2_nbits", run_n, 40);
    chk("s2_run0", run_t[31] - run_t[0], 31);
    chk("s2_bubble", run_t[32] - run_t[31], 2);
    chk("s2_latch_t", latch_t, run_t[39] + 1);
    wb_rd(A_REM, 32'h0, "s2_remain");
    wb_rd(A_STAT, 32'h0000_000A, "s2_status");

    // 64 bits with only one word queued: stall, then resume.
    wb_wr(A_DATA, 32'hF0F0_1234);
    push_bits(32'hF0F0_1234, 32'h0BAD_BEEF, 64);
    run_n = 0;
    wb_wr(A_CTRL, 32'h0040_0001);
    wait_shifts(32, 200);
    repeat (6) @(posedge clk);
    #1;
    chk("s3_stall_shift", cshift, 0);
    chk("s3_stall_n", run_n, 32);
    wb_rd(A_STAT, 32'h0000_0009, "s3_status");
    wb_rd(A_REM, 32'd32, "s3_remain");
    wb_wr(A_DATA, 32'h0BAD_BEEF);
    wait_latch(200);
    chk("s3_nbits", run_n, 64);
    chk("s3_latch_t", latch_t, run_t[63] + 1);

    // Overflow while idle, then W1C of OVF and DONE.
    for (int i = 0; i < 5; i++) wb_wr(A_DATA, 32'h100 + i);
    wb_rd(A_STAT, 32'h0000_0426, "s4_ovf");
    wb_wr(A_STAT, 32'h22);
    wb_rd(A_STAT, 32'h0000_0404, "s4_w1c");
    wb_wr(A_CTRL, 32'h2);
    wb_rd(A_STAT, 32'h0000_0008, "s4_flush");

    // ABORT beats START in the same write.
    wb_wr(A_DATA, 32'hFFFF_FFFF);
    wb_wr(A_CTRL, 32'h0010_0003);
    repeat (4) @(posedge clk);
    wb_rd(A_STAT, 32'h0000_0008, "abort_start");

    // ABORT mid-shift.
    wb_wr(A_DATA, 32'h5555_AAAA);
    wb_wr(A_DATA, 32'h0000_00FF);
    push_bits(32'h5555_AAAA, 32'h0000_00FF, 40);
    run_n = 0;
    wb_wr(A_CTRL, 32'h0028_0001);
    wait_shifts(10, 200);
    l0 = latch_n;
    wb_wr(A_CTRL, 32'h2);
    chk("s5_shift", cshift, 0);
    bit_q.delete();
    repeat (50) @(posedge clk);
    #1;
    chk("s5_nolatch", latch_n, l0);
    wb_rd(A_STAT, 32'h0000_0008, "s5_status");
    wb_rd(A_REM, 32'h0, "s5_remain");

    // Reset in the middle of a shift.
    wb_wr(A_DATA, 32'h0000_C3C3);
    push_bits(32'h0000_C3C3, 32'h0, 16);
    run_n = 0;
    wb_wr(A_CTRL, 32'h0010_0005);
    wait_shifts(4, 200);
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    chk("s6_dat", rdat, 0);
    chk("s6_outs", {ack, cdata, cshift, clatch, irq}, 0);
    bit_q.delete();
    rst_n = 1;
    wb_rd(A_STAT, 32'h0000_0008, "s6_status");
    wb_rd(A_CTRL, 32'h0, "s6_ctrl");
    wb_rd(A_REM, 32'h0, "s6_remain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unigate_cfg_seq.md
UNIGATE_CFG_SEQ -- requirements
Module: unigate_cfg_seq

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
- BASE_ADDR, 32'h3000_0000, Wishbone base address; the block decodes a 16-byte window.
- FIFO_DEPTH, 4, depth in 32-bit words of the config-data FIFO; power of two, range 2..16.
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
- wb_clk_i, in, 1, the single clock.
- wb_rst_ni, in, 1, reset; synchronous and active-low.
- wbs_cyc_i, in, 1, Wishbone cycle.
- wbs_stb_i, in, 1, Wishbone strobe.
- wbs_we_i, in, 1, write enable.
- wbs_sel_i, in, 4, byte selects; ignored, every access is a full word.
- wbs_adr_i, in, 32, byte address.
- wbs_dat_i, in, 32, write data.
- wbs_ack_o, out, 1, acknowledge.
- wbs_dat_o, out, 32, read data.
- cfg_data_o, out, 1, serial config bit to the unigate chain.
- cfg_shift_o, out, 1, chain shift enable; cfg_data_o is sampled when this is 1.
- cfg_latch_o, out, 1, one-cycle pulse that commits the chain contents.
- irq_o, out, 1, level interrupt.

Function
REQ-003 A hit SHALL be cyc&stb&(adr[31:4]==BASE_ADDR[31:4]); the register is selected by adr[3:2].
REQ-004 On a hit, wbs_ack_o SHALL assert for exactly one cycle, in the cycle after the hit, and SHALL be 0 in the following cycle even if stb stays high. One transaction takes two cycles.
REQ-005 On a non-hit, wbs_ack_o SHALL stay 0.
REQ-006 wbs_dat_o SHALL carry read data only while wbs_ack_o=1 and a read is being acknowledged; otherwise it SHALL be 0.
REQ-007 Writes SHALL take effect in the cycle in which the ack is asserted.
REQ-008 The register map SHALL be:
- 0x0 CTRL (R/W): bit0 START (write-1 pulse, reads 0); bit1 ABORT (write-1 pulse, reads 0); bit2 IRQ_EN; [31:16] LEN, the chain length in bits.
- 0x4 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, W1C); bit2 FULL (RO); bit3 EMPTY (RO); bit5 OVF (sticky, W1C); [12:8] fifo level (RO).
- 0x8 DATA (WO): a write pushes wbs_dat_i into the FIFO; reads return 0.
- 0xC REMAIN (RO): [15:0] bits still to shift.
REQ-009 A DATA write while the FIFO is full SHALL be dropped and SHALL set OVF.
REQ-010 A DATA write while the FIFO is not full SHALL push the word, including while BUSY.
REQ-011 The FSM states SHALL be IDLE, LOAD, SHIFT and LATCH.
REQ-012 IDLE: START with LEN!=0 SHALL go to LOAD next cycle, with REMAIN<=LEN and DONE cleared. START with LEN==0 SHALL be ignored.
REQ-013 LOAD: if the FIFO is non-empty, the block SHALL pop the head word into a 32-bit shift register, set bit index 0 and go to SHIFT. If the FIFO is empty it SHALL stay in LOAD with cfg_shift_o=0 (stall, no error).
REQ-014 SHIFT: each cycle cfg_shift_o=1 and cfg_data_o = the shift register bit at the current index (LSB first). REMAIN SHALL decrement and the index SHALL increment.
REQ-015 SHIFT exit: after the shift where REMAIN reaches 0, go to LATCH. Otherwise, after the shift of bit 31, go to LOAD. This gives a one-cycle bubble per word.
REQ-016 Unused bits of the final word SHALL be discarded.
REQ-017 LATCH: cfg_latch_o=1 for one cycle, then go to IDLE and set DONE.
REQ-018 BUSY SHALL be 1 in every state except IDLE.
REQ-019 START while BUSY SHALL be ignored. A LEN write while BUSY SHALL update the register but SHALL NOT affect the load in progress.
REQ-020 ABORT in any state SHALL go to IDLE next cycle, flush the FIFO and set REMAIN<=0. No latch pulse SHALL follow and DONE SHALL NOT be set. ABORT takes priority over START in the same write.
REQ-021 A simultaneous FIFO push and pop SHALL leave the level unchanged and SHALL NOT set OVF, even at full.
REQ-022 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 irq_o SHALL equal DONE & IRQ_EN, registered.
REQ-024 cfg_data_o SHALL be 0 whenever cfg_shift_o=0.

Reset
REQ-025 When wb_rst_ni=0 at a clock edge, all of the following SHALL take effect on that edge, overriding any in-flight transfer or shift:
- FSM to IDLE.
- FIFO empty.
- LEN, IRQ_EN, DONE, OVF and REMAIN cleared.
- wbs_ack_o, wbs_dat_o, cfg_data_o, cfg_shift_o, cfg_latch_o and irq_o all 0.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Push 0x0000_00A5, write CTRL LEN=8, START, IRQ_EN -> eight shifts with data 1,0,1,0,0,1,0,1; latch pulse one cycle after the last shift; DONE=1; irq_o=1.
- LEN=40, push two words -> 32 shifts, one-cycle bubble, 8 shifts, latch; REMAIN reads 0 at the end.
- LEN=64, push only one word -> stall in LOAD with cfg_shift_o=0 after 32 shifts; the second push resumes shifting; the latch follows after 64 total shifts.
- Push FIFO_DEPTH+1 words while IDLE -> FULL=1, OVF=1, level=FIFO_DEPTH; write 0x22 to STATUS -> OVF and DONE cleared.
- ABORT mid-SHIFT -> cfg_shift_o=0 next cycle; no latch; EMPTY=1; DONE stays 0.
- Drive wb_rst_ni low during SHIFT -> all outputs 0 at the next edge; STATUS reads 0x0000_0008 afterwards.
